// File: rtl/lut_mult_scheduler_if.sv
// Handshake bundle between two multiply requesters and the shared scheduler.
interface lut_mult_scheduler_if #(
  parameter int SIZE = 8
);
  logic              req0;
  logic [SIZE-1:0]   a0;
  logic [7:0]        b0;
  logic              req1;
  logic [SIZE-1:0]   a1;
  logic [7:0]        b1;
  logic [1:0]        gnt;
  logic              busy;
  logic              done;
  logic              done_id;
  logic [2*SIZE-1:0] result;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt, busy, done, done_id, result
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt, busy, done, done_id, result
  );
endinterface

// File: rtl/lut_mult_scheduler.sv
// Round-robin scheduler time-sharing one SIZE x 4 multiplier between two
// requesters; 8-bit B is consumed low nibble first, then high nibble.
module lut_multiplier_4b #(
  parameter int SIZE = 8
) (
  input  logic              reset,
  input  logic [SIZE-1:0]   a,
  input  logic [3:0]        b,
  output logic [SIZE+3:0]   product
);
  localparam int N = (SIZE + 3) / 4;
  localparam int P = SIZE + 4;

  logic [4*N-1:0] a_pad;
  logic [7:0]     pp [N];
  logic [P-1:0]   sum;

  always_comb begin
    a_pad = '0;
    a_pad[SIZE-1:0] = a;
  end

  // Each A nibble times B is one 4x4 table entry
  for (genvar i = 0; i < N; i++) begin : g_pp
    assign pp[i] = {4'b0, a_pad[4*i +: 4]} * {4'b0, b};
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++)
      sum = sum + (P'(pp[i]) << (4 * i));
  end

  assign product = reset ? '0 : sum;
endmodule

module lut_mult_scheduler #(
  parameter int SIZE = 8
) (
  input  logic clk,
  input  logic reset,
  lut_mult_scheduler_if.slave bus
);
  localparam int W = 2 * SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            any_req;
  logic            win;
  logic            prio;
  logic            id;
  logic [SIZE-1:0] a_reg;
  logic [7:0]      b_reg;
  logic [3:0]      mult_b;
  logic [SIZE+3:0] product;
  logic [W-1:0]    acc;
  logic [1:0]      gnt;
  logic            busy;
  logic            done;
  logic            done_id;
  logic [W-1:0]    result;

  assign any_req = bus.req0 | bus.req1;
  // prio names the requester that wins a tie
  assign win = (bus.req0 & bus.req1) ? prio : bus.req1;

  lut_multiplier_4b #(.SIZE(SIZE)) u_mult (
    .reset   (reset),
    .a       (a_reg),
    .b       (mult_b),
    .product (product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (any_req) state_nx = S_LOW;
      S_LOW:  state_nx = S_HIGH;
      S_HIGH: state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mult_b = 4'h0;
    unique case (state)
      S_LOW:  mult_b = b_reg[3:0];
      S_HIGH: mult_b = b_reg[7:4];
      default: mult_b = 4'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      id      <= 1'b0;
      prio    <= 1'b0;
      acc     <= '0;
      gnt     <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            a_reg <= win ? bus.a1 : bus.a0;
            b_reg <= win ? bus.b1 : bus.b0;
            id    <= win;
            prio  <= ~win;
            gnt   <= win ? 2'b10 : 2'b01;
            busy  <= 1'b1;
          end
        end
        S_LOW: acc <= W'(product);
        S_HIGH: begin
          result  <= acc + (W'(product) << 4);
          done    <= 1'b1;
          done_id <= id;
        end
        S_DONE: begin
          gnt  <= 2'b00;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.done_id = done_id;
  assign bus.result  = result;
endmodule

// File: tb/tb_lut_mult_scheduler.sv
// Directed bench for lut_mult_scheduler: arbitration, latency, products,
// operand capture and asynchronous abort.
module tb_lut_mult_scheduler;
  logic clk;
  logic reset;
  int   ncmp;
  int   nerr;

  lut_mult_scheduler_if #(.SIZE(8)) bus ();

  lut_mult_scheduler #(.SIZE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    ncmp++;
    if (bus.gnt !== 2'b00) begin
      nerr++; $display("FAIL reset_gnt got %b want 00", bus.gnt);
    end
    ncmp++;
    if ({bus.busy, bus.done, bus.done_id} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_flags got %b want 000",
               {bus.busy, bus.done, bus.done_id});
    end
    ncmp++;
    if (bus.result !== 16'h0000) begin
      nerr++; $display("FAIL reset_result got %h want 0000", bus.result);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single0();
    bus.req0 = 1'b1; bus.a0 = 8'hFF; bus.b0 = 8'hFF;
    step();
    ncmp++;
    if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
      nerr++;
      $display("FAIL s0_grant got gnt=%b busy=%b want 01/1",
               bus.gnt, bus.busy);
    end
    step();
    ncmp++;
    if (bus.done !== 1'b0) begin
      nerr++; $display("FAIL s0_early_done got %b want 0", bus.done);
    end
    step();
    ncmp++;
    if (bus.done !== 1'b1 || bus.result !== 16'hFE01 ||
        bus.done_id !== 1'b0) begin
      nerr++;
      $display("FAIL s0_done got d=%b r=%h id=%b want 1/fe01/0",
               bus.done, bus.result, bus.done_id);
    end
    bus.req0 = 1'b0;
    step();
    ncmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== 2'b00 ||
        bus.result !== 16'hFE01) begin
      nerr++;
      $display("FAIL s0_after got d=%b b=%b g=%b r=%h want 0/0/00/fe01",
               bus.done, bus.busy, bus.gnt, bus.result);
    end
  endtask

  task automatic test_single1();
    bus.req1 = 1'b1; bus.a1 = 8'd13; bus.b1 = 8'd200;
    step();
    ncmp++;
    if (bus.gnt !== 2'b10) begin
      nerr++; $display("FAIL s1_grant got %b want 10", bus.gnt);
    end
    step();
    step();
    ncmp++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0A28 ||
        bus.done_id !== 1'b1) begin
      nerr++;
      $display("FAIL s1_done got d=%b r=%h id=%b want 1/0a28/1",
               bus.done, bus.result, bus.done_id);
    end
    bus.req1 = 1'b0;
    step();
  endtask

  task automatic test_both_after_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 8'd3; bus.b0 = 8'd5;
    bus.req1 = 1'b1; bus.a1 = 8'd7; bus.b1 = 8'd9;
    step();
    ncmp++;
    if (bus.gnt !== 2'b01) begin
      nerr++; $display("FAIL both_first_gnt got %b want 01", bus.gnt);
    end
    step();
    step();
    ncmp++;
    if (bus.done !== 1'b1 || bus.done_id !== 1'b0 ||
        bus.result !== 16'h000F) begin
      nerr++;
      $display("FAIL both_first_done got d=%b id=%b r=%h want 1/0/000f",
               bus.done, bus.done_id, bus.result);
    end
    bus.req0 = 1'b0;
    step();
    ncmp++;
    if (bus.gnt !== 2'b00) begin
      nerr++; $display("FAIL both_gap_gnt got %b want 00", bus.gnt);
    end
    step();
    ncmp++;
    if (bus.gnt !== 2'b10) begin
      nerr++; $display("FAIL both_second_gnt got %b want 10", bus.gnt);
    end
    step();
    step();
    ncmp++;
    if (bus.done !== 1'b1 || bus.done_id !== 1'b1 ||
        bus.result !== 16'h003F) begin
      nerr++;
      $display("FAIL both_second_done got d=%b id=%b r=%h want 1/1/003f",
               bus.done, bus.done_id, bus.result);
    end
    bus.req1 = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_r;
    logic [1:0]  exp_g;
    bus.req0 = 1'b1; bus.a0 = 8'h02; bus.b0 = 8'h11;
    bus.req1 = 1'b1; bus.a1 = 8'h10; bus.b1 = 8'h10;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (n % 2 == 0) ? 16'h0022 : 16'h0100;
      step();
      ncmp++;
      if (bus.gnt !== exp_g || bus.done !== 1'b0) begin
        nerr++;
        $display("FAIL b2b_gnt op%0d got g=%b d=%b want %b/0",
                 n, bus.gnt, bus.done, exp_g);
      end
      step();
      step();
      ncmp++;
      if (bus.done !== 1'b1 || bus.done_id !== n[0] ||
          bus.result !== exp_r) begin
        nerr++;
        $display("FAIL b2b_done op%0d got d=%b id=%b r=%h want 1/%b/%h",
                 n, bus.done, bus.done_id, bus.result, n[0], exp_r);
      end
      step();
      ncmp++;
      if (bus.done !== 1'b0) begin
        nerr++; $display("FAIL b2b_pulse op%0d got %b want 0", n, bus.done);
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    step();
  endtask

  task automatic test_zero();
    bus.req0 = 1'b1; bus.a0 = 8'hA5; bus.b0 = 8'h00;
    step();
    step();
    ncmp++;
    if (bus.result !== 16'h0100) begin
      nerr++; $display("FAIL zero_hold got %h want 0100", bus.result);
    end
    step();
    ncmp++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0000) begin
      nerr++;
      $display("FAIL zero_b got d=%b r=%h want 1/0000",
               bus.done, bus.result);
    end
    bus.a0 = 8'h00; bus.b0 = 8'hA5;
    step();
    step();
    ncmp++;
    if (bus.gnt !== 2'b01) begin
      nerr++; $display("FAIL zero_a_gnt got %b want 01", bus.gnt);
    end
    bus.a0 = 8'hFF; bus.b0 = 8'hFF;
    bus.req0 = 1'b0;
    step();
    step();
    ncmp++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0000) begin
      nerr++;
      $display("FAIL zero_a got d=%b r=%h want 1/0000",
               bus.done, bus.result);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.req0 = 1'b1; bus.a0 = 8'h12; bus.b0 = 8'h34;
    step();
    step();
    #1 reset = 1'b1;
    #1;
    ncmp++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.result !== 16'h0000) begin
      nerr++;
      $display("FAIL abort_async got g=%b b=%b d=%b r=%h want 00/0/0/0000",
               bus.gnt, bus.busy, bus.done, bus.result);
    end
    step();
    ncmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      nerr++;
      $display("FAIL abort_hold got d=%b b=%b want 0/0",
               bus.done, bus.busy);
    end
    reset = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 8'h44; bus.b1 = 8'h44;
    step();
    ncmp++;
    if (bus.gnt !== 2'b01) begin
      nerr++; $display("FAIL abort_regnt got %b want 01", bus.gnt);
    end
    step();
    ncmp++;
    if (bus.done !== 1'b0) begin
      nerr++; $display("FAIL abort_early got %b want 0", bus.done);
    end
    step();
    ncmp++;
    if (bus.done !== 1'b1 || bus.done_id !== 1'b0 ||
        bus.result !== 16'h03A8) begin
      nerr++;
      $display("FAIL abort_redo got d=%b id=%b r=%h want 1/0/03a8",
               bus.done, bus.done_id, bus.result);
    end
    idle_inputs();
    step();
    step();
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single0();
    test_single1();
    test_both_after_reset();
    test_back_to_back();
    test_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
